// File: rtl/alu_uart_if_if.sv
// alu_uart_if_if: UART/ALU-side bus bundle for alu_uart_if.
// master is the sequencer's view, slave is the UART/ALU environment's view.
interface alu_uart_if_if #(
    parameter int DATA_BITS = 8,
    parameter int OP_BITS   = 8
);
    logic [DATA_BITS-1:0] i_rx_data;
    logic                 i_rx_done;
    logic [DATA_BITS-1:0] i_alu_result;
    logic [DATA_BITS-1:0] o_alu_a;
    logic [DATA_BITS-1:0] o_alu_b;
    logic [OP_BITS-1:0]   o_alu_op;
    logic [DATA_BITS-1:0] o_tx_data;
    logic                 o_tx_start;
    logic                 i_tx_done;
    logic                 o_busy;
    logic                 o_timeout;

    modport master (
        input  i_rx_data, i_rx_done, i_alu_result, i_tx_done,
        output o_alu_a, o_alu_b, o_alu_op, o_tx_data, o_tx_start, o_busy, o_timeout
    );
    modport slave (
        output i_rx_data, i_rx_done, i_alu_result, i_tx_done,
        input  o_alu_a, o_alu_b, o_alu_op, o_tx_data, o_tx_start, o_busy, o_timeout
    );
endinterface

// File: rtl/alu_uart_if.sv
// alu_uart_if: collects A, B, opcode bytes from UART, captures the ALU result and sends it back.
// Optional inter-byte timeout enabled by defining ALU_UART_IF_TIMEOUT_EN.
module alu_uart_if #(
    parameter int DATA_BITS      = 8,
    parameter int OP_BITS        = 8,
    parameter int TIMEOUT_CYCLES = 1000000
) (
    input logic         i_clk,
    input logic         i_rst_n,
    alu_uart_if_if.master bus
);
    typedef enum logic [2:0] {IDLE, WAIT_B, WAIT_OP, CAPTURE, SEND, WAIT_TX} state_t;

    state_t               state_q, state_d;
    logic [DATA_BITS-1:0] a_q, a_d, b_q, b_d, tx_q, tx_d;
    logic [OP_BITS-1:0]   op_q, op_d;
    logic                 tmo;
    logic [OP_BITS+DATA_BITS-1:0] rx_ext;

    // Widened so the opcode slice zero-extends when OP_BITS exceeds DATA_BITS
    assign rx_ext = {{OP_BITS{1'b0}}, bus.i_rx_data};

`ifdef ALU_UART_IF_TIMEOUT_EN
    localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
    logic [CW-1:0] cnt_q, cnt_d;
    logic          waiting, timeout_q;
    assign waiting = (state_q == WAIT_B) || (state_q == WAIT_OP);
    assign tmo     = waiting && !bus.i_rx_done && (cnt_q == CW'(TIMEOUT_CYCLES - 1));
    assign cnt_d   = (waiting && !bus.i_rx_done && !tmo) ? cnt_q + 1'b1 : '0;
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            cnt_q     <= '0;
            timeout_q <= 1'b0;
        end else begin
            cnt_q     <= cnt_d;
            timeout_q <= tmo;
        end
    end
    assign bus.o_timeout = timeout_q;
`else
    assign tmo           = 1'b0;
    assign bus.o_timeout = 1'b0;
`endif

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q <= IDLE;
            a_q     <= '0;
            b_q     <= '0;
            op_q    <= '0;
            tx_q    <= '0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            op_q    <= op_d;
            tx_q    <= tx_d;
        end
    end

    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        op_d    = op_q;
        tx_d    = tx_q;
        case (state_q)
            IDLE:    if (bus.i_rx_done) begin a_d = bus.i_rx_data; state_d = WAIT_B; end
            WAIT_B:  if (bus.i_rx_done) begin b_d = bus.i_rx_data; state_d = WAIT_OP; end
                     else if (tmo) state_d = IDLE;
            WAIT_OP: if (bus.i_rx_done) begin op_d = rx_ext[OP_BITS-1:0]; state_d = CAPTURE; end
                     else if (tmo) state_d = IDLE;
            CAPTURE: begin tx_d = bus.i_alu_result; state_d = SEND; end
            SEND:    state_d = WAIT_TX;
            WAIT_TX: if (bus.i_tx_done) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Decoded straight from state so reset kills tx_start without waiting for a clock
    assign bus.o_alu_a    = a_q;
    assign bus.o_alu_b    = b_q;
    assign bus.o_alu_op   = op_q;
    assign bus.o_tx_data  = tx_q;
    assign bus.o_tx_start = (state_q == SEND);
    assign bus.o_busy     = (state_q == CAPTURE) || (state_q == SEND) || (state_q == WAIT_TX);
endmodule

// File: tb/tb_alu_uart_if.sv
// tb_alu_uart_if: table-driven frames plus hand sequences for drops, coincident strobes, resets, timeout.
module tb_alu_uart_if;
`ifdef ALU_UART_IF_TIMEOUT_EN
    localparam int TMO = 16;
`else
    localparam int TMO = 1000000;
`endif
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   tests = 0;
    int   fails = 0;

    alu_uart_if_if #(.DATA_BITS(8), .OP_BITS(8)) bus ();
    alu_uart_if #(.DATA_BITS(8), .OP_BITS(8), .TIMEOUT_CYCLES(TMO)) dut (
        .i_clk  (clk),
        .i_rst_n(rst_n),
        .bus    (bus.master)
    );

    always #5 clk = ~clk;

    // Stand-in combinational ALU
    assign bus.i_alu_result = (bus.o_alu_op == 8'h20) ? bus.o_alu_a + bus.o_alu_b :
                              (bus.o_alu_op == 8'h22) ? bus.o_alu_a - bus.o_alu_b :
                              (bus.o_alu_op == 8'h24) ? bus.o_alu_a & bus.o_alu_b :
                              (bus.o_alu_op == 8'h25) ? bus.o_alu_a | bus.o_alu_b :
                              (bus.o_alu_op == 8'h26) ? bus.o_alu_a ^ bus.o_alu_b : 8'h00;

    typedef struct {
        logic [7:0] a, b, op, res;
    } vec_t;
    vec_t vecs[6];

    task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", n, act, exp);
        end
    endtask

    task automatic send_byte(input logic [7:0] b);
        @(negedge clk);
        bus.i_rx_data = b;
        bus.i_rx_done = 1'b1;
        @(negedge clk);
        bus.i_rx_done = 1'b0;
    endtask

    task automatic tx_done();
        @(negedge clk);
        bus.i_tx_done = 1'b1;
        @(negedge clk);
        bus.i_tx_done = 1'b0;
    endtask

    task automatic chk_zero(input string n);
        chk({n, "_a"}, bus.o_alu_a, 0);
        chk({n, "_b"}, bus.o_alu_b, 0);
        chk({n, "_op"}, bus.o_alu_op, 0);
        chk({n, "_tx"}, bus.o_tx_data, 0);
        chk({n, "_start"}, bus.o_tx_start, 0);
        chk({n, "_busy"}, bus.o_busy, 0);
        chk({n, "_tmo"}, bus.o_timeout, 0);
    endtask

    initial begin
        int starts, tmos, seen_at;
        vecs[0] = '{8'h05, 8'h03, 8'h20, 8'h08};
        vecs[1] = '{8'h03, 8'h05, 8'h22, 8'hFE};
        vecs[2] = '{8'h0F, 8'hF0, 8'h25, 8'hFF};
        vecs[3] = '{8'hFF, 8'h01, 8'h20, 8'h00};
        vecs[4] = '{8'hAA, 8'h55, 8'h26, 8'hFF};
        vecs[5] = '{8'hC3, 8'h0F, 8'h24, 8'h03};
        bus.i_rx_data = '0;
        bus.i_rx_done = 1'b0;
        bus.i_tx_done = 1'b0;
        #1 chk_zero("reset");
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 6; i++) begin
            send_byte(vecs[i].a);
            send_byte(vecs[i].b);
            send_byte(vecs[i].op);
            chk("alu_a", bus.o_alu_a, vecs[i].a);
            chk("alu_b", bus.o_alu_b, vecs[i].b);
            chk("alu_op", bus.o_alu_op, vecs[i].op);
            chk("cap_start", bus.o_tx_start, 0);
            chk("cap_busy", bus.o_busy, 1);
            @(negedge clk);
            chk("send_start", bus.o_tx_start, 1);
            chk("send_data", bus.o_tx_data, vecs[i].res);
            @(negedge clk);
            chk("wait_start", bus.o_tx_start, 0);
            chk("wait_busy", bus.o_busy, 1);
            send_byte(8'h11);
            chk("drop_a", bus.o_alu_a, vecs[i].a);
            chk("drop_start", bus.o_tx_start, 0);
            tx_done();
            chk("done_busy", bus.o_busy, 0);
            chk("hold_data", bus.o_tx_data, vecs[i].res);
        end

        // Coincident tx_done/rx_done in WAIT_TX, then a byte on the very next cycle
        send_byte(8'h01);
        send_byte(8'h02);
        send_byte(8'h20);
        repeat (2) @(negedge clk);
        bus.i_tx_done = 1'b1;
        bus.i_rx_done = 1'b1;
        bus.i_rx_data = 8'h77;
        @(negedge clk);
        bus.i_tx_done = 1'b0;
        bus.i_rx_done = 1'b0;
        chk("coin_busy", bus.o_busy, 0);
        chk("coin_a", bus.o_alu_a, 8'h01);
        bus.i_rx_data = 8'h44;
        bus.i_rx_done = 1'b1;
        @(negedge clk);
        bus.i_rx_done = 1'b0;
        chk("next_a", bus.o_alu_a, 8'h44);

        // Reset in WAIT_OP
        send_byte(8'h55);
        #1 rst_n = 1'b0;
        #1 chk_zero("rst_waitop");
        @(negedge clk);
        rst_n = 1'b1;
        send_byte(8'h01);
        chk("post_rst_a", bus.o_alu_a, 8'h01);
        chk("post_rst_b", bus.o_alu_b, 8'h00);
        starts = 0;
        repeat (8) begin
            @(negedge clk);
            starts += int'(bus.o_tx_start);
        end
        chk("post_rst_nostart", starts, 0);

        // Reset during SEND: finish the frame, then reset while tx_start is high
        send_byte(8'h02);
        send_byte(8'h20);
        @(negedge clk);
        chk("pre_rst_start", bus.o_tx_start, 1);
        #1 rst_n = 1'b0;
        #1 chk("rst_send_start", bus.o_tx_start, 0);
        chk("rst_send_busy", bus.o_busy, 0);
        @(negedge clk);
        rst_n = 1'b1;

        // Inter-byte timeout behaviour
        send_byte(8'h09);
        tmos = 0;
        seen_at = 0;
        for (int i = 1; i <= 100; i++) begin
            @(negedge clk);
            if (bus.o_timeout) begin
                tmos++;
                if (seen_at == 0) seen_at = i;
            end
        end
`ifdef ALU_UART_IF_TIMEOUT_EN
        chk("tmo_count", tmos, 1);
        chk("tmo_cycle", seen_at, 16);
        send_byte(8'h0A);
        chk("tmo_next_a", bus.o_alu_a, 8'h0A);
        chk("tmo_b_kept", bus.o_alu_b, 8'h00);
`else
        chk("notmo_count", tmos, 0);
        send_byte(8'h0A);
        chk("notmo_a", bus.o_alu_a, 8'h09);
        chk("notmo_b", bus.o_alu_b, 8'h0A);
`endif

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
